// File: rtl/coin_pkg.sv
// Shared coin codes and output-FSM state encodings for the coin input conditioner.
package coin_pkg;

  typedef logic [1:0] coin_t;

  localparam coin_t COIN_NONE = 2'd0;
  localparam coin_t COIN_ONE  = 2'd1;
  localparam coin_t COIN_TWO  = 2'd2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EMIT = 2'd1,
    GAP  = 2'd2
  } out_state_t;

  // Queue entry code (0 = one rupee, 1 = two rupees) to FSM coin code.
  function automatic coin_t code_to_coin(input logic code);
    return code ? COIN_TWO : COIN_ONE;
  endfunction

endpackage

// File: rtl/coin_debounce.sv
// One coin sensor: 2-flop synchroniser, stability counter and press-event detector.
module coin_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic sensor_n,
  output logic press_event
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic [1:0]       sync_q;
  logic             level_q;
  logic             level_seen_q;
  logic [CNT_W-1:0] cnt_q;

  // Levels are held active-high internally; reset leaves everything deasserted.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q       <= '0;
      level_q      <= 1'b0;
      level_seen_q <= 1'b0;
      cnt_q        <= '0;
      press_event  <= 1'b0;
    end else begin
      sync_q       <= {sync_q[0], ~sensor_n};
      level_seen_q <= level_q;
      press_event  <= level_q & ~level_seen_q;
      if (sync_q[1] != level_q) begin
        if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
          level_q <= sync_q[1];
          cnt_q   <= '0;
        end else begin
          cnt_q <= cnt_q + CNT_W'(1);
        end
      end else begin
        cnt_q <= '0;
      end
    end
  end

endmodule

// File: rtl/coin_input_conditioner.sv
// Debounces both coin sensors, queues accepted coins and emits spaced one-cycle
// coin codes to the vending FSM, rejecting jammed or unstorable coins.
module coin_input_conditioner
  import coin_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned QUEUE_DEPTH     = 2,
  parameter int unsigned GAP_CYCLES      = 1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           coin_rs1_n,
  input  logic                           coin_rs2_n,
  input  logic                           accept_en,
  output logic [1:0]                     coin,
  output logic                           coin_reject,
  output logic [$clog2(QUEUE_DEPTH):0]   queue_count
);

  localparam int unsigned PTR_W = $clog2(QUEUE_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned GAP_W = $clog2(GAP_CYCLES + 1);

  logic             ev_rs1;
  logic             ev_rs2;
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic             mem_q [QUEUE_DEPTH];
  out_state_t       state_q;
  logic [GAP_W-1:0] gap_q;

  logic push_req_c;
  logic jam_c;
  logic full_c;
  logic pop_c;
  logic push_c;
  logic drop_c;

  coin_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_rs1 (
    .clk         (clk),
    .reset       (reset),
    .sensor_n    (coin_rs1_n),
    .press_event (ev_rs1)
  );

  coin_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_rs2 (
    .clk         (clk),
    .reset       (reset),
    .sensor_n    (coin_rs2_n),
    .press_event (ev_rs2)
  );

  // Classification: a lone event is a coin, simultaneous events are a jam.
  always_comb begin
    push_req_c = ev_rs1 ^ ev_rs2;
    jam_c      = ev_rs1 & ev_rs2;
    full_c     = (queue_count == CNT_W'(QUEUE_DEPTH));
    pop_c      = (state_q == IDLE) && (queue_count != '0) && accept_en;
    push_c     = push_req_c && (!full_c || pop_c);
    drop_c     = push_req_c && full_c && !pop_c;
  end

  always_ff @(posedge clk) begin
    if (push_c) begin
      mem_q[wr_ptr_q] <= ev_rs2;
    end
  end

  // Queue pointers, occupancy and reject pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      queue_count <= '0;
      coin_reject <= 1'b0;
    end else begin
      if (push_c) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_c)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      queue_count <= queue_count + CNT_W'(push_c) - CNT_W'(pop_c);
      coin_reject <= jam_c | drop_c;
    end
  end

  // Output FSM: pop in IDLE, pulse during EMIT, hold coin low through GAP.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      gap_q   <= '0;
      coin    <= COIN_NONE;
    end else begin
      coin <= COIN_NONE;
      case (state_q)
        IDLE: begin
          if (pop_c) begin
            coin    <= code_to_coin(mem_q[rd_ptr_q]);
            state_q <= EMIT;
          end
        end
        EMIT: begin
          gap_q   <= GAP_W'(GAP_CYCLES);
          state_q <= GAP;
        end
        GAP: begin
          if (gap_q <= GAP_W'(1)) begin
            gap_q   <= '0;
            state_q <= IDLE;
          end else begin
            gap_q <= gap_q - GAP_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/coin_input_conditioner.md
Name: coin_input_conditioner

Overview:
- Front-end stage that feeds the vending-machine FSM's 2-bit coin input.
- Synchronises and debounces two raw active-low coin-sensor lines (1-rupee and 2-rupee slots).
- Turns each accepted coin into a single-cycle coin code and queues coins that arrive while the FSM cannot take them.
- Spaces the pulses so the FSM's PRODUCT/CHANGE cycles never swallow a coin, and rejects coins it cannot store or cannot classify.

Parameters:
- DEBOUNCE_CYCLES, 16: consecutive stable synchronised cycles needed before a sensor level change is accepted; legal range 1 to 255.
- QUEUE_DEPTH, 2: coin queue entries; power of two, at least 2.
- GAP_CYCLES, 1: minimum cycles of coin=0 after every coin pulse; at least 1.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-low reset
- coin_rs1_n  input  1  raw 1-rupee sensor, active-low, asynchronous to clk
- coin_rs2_n  input  1  raw 2-rupee sensor, active-low, asynchronous to clk
- accept_en  input  1  downstream ready; low while the machine is dispensing or in service
- coin  output  2  0=none, 1=ONE, 2=TWO; 3 is never driven
- coin_reject  output  1  1-cycle pulse: drive the coin-return flap
- queue_count  output  $clog2(QUEUE_DEPTH)+1  coins currently queued

Behaviour:
- Reset (reset low, asynchronous):
  - coin=0, coin_reject=0, queue_count=0.
  - Queue emptied, synchronisers cleared to deasserted, debounced levels deasserted, debounce counters 0, output FSM in IDLE.
  - Any coin in flight is lost.
- Per channel:
  - 2-flop synchroniser, then debounce counter.
  - The counter increments while the synchronised level differs from the debounced level and clears to 0 otherwise.
  - When it reaches DEBOUNCE_CYCLES, the debounced level flips and the counter clears.
  - A deasserted-to-asserted flip of the debounced level raises a 1-cycle event.
  - A sensor held low across reset release gives exactly one event after DEBOUNCE_CYCLES+2 cycles.
- Event classification, registered 1 cycle:
  - RS1 event only: push code 0.
  - RS2 event only: push code 1.
  - Both events in the same cycle: jam. No push; coin_reject pulses 1 cycle.
- Full queue:
  - Push while full with no pop in the same cycle: the coin is dropped and coin_reject pulses 1 cycle.
  - Push and pop in the same cycle while full: both happen and queue_count is unchanged.
- Queue order is FIFO; pointers wrap modulo QUEUE_DEPTH.
- Output FSM states: IDLE, EMIT, GAP.
  - IDLE: if queue_count>0 and accept_en=1, pop the head and go to EMIT. Otherwise stay; coin=0.
  - EMIT: coin = head code + 1 for exactly one cycle. Load the gap counter with GAP_CYCLES and go to GAP.
  - GAP: coin=0 and the counter decrements; at 0 go to IDLE. accept_en is ignored in GAP.
- coin is registered and is high for exactly 1 cycle per accepted coin. Back-to-back coins are separated by GAP_CYCLES+1 zero cycles, because IDLE takes one cycle to pop.
- accept_en dropping while in EMIT does not cancel the pulse already committed.
- Latency: queue empty, accept_en=1, sensor low and bounce-free. coin asserts DEBOUNCE_CYCLES+5 rising edges after the first edge that samples the sensor low:
  - 2 synchroniser edges
  - DEBOUNCE_CYCLES counting edges
  - 1 event register
  - 1 queue push
  - 1 IDLE-to-EMIT transition
- Sensor bounce shorter than DEBOUNCE_CYCLES cycles produces no event and leaves the debounced level unchanged.
- Sensor release is debounced identically but produces no event.

Decomposition:
- Shared package coin_pkg holds:
  - coin codes COIN_NONE=2'd0, COIN_ONE=2'd1, COIN_TWO=2'd2; the FSM should move to these as well.
  - output FSM state encodings IDLE, EMIT, GAP.
- One natural sub-module: coin_debounce (synchroniser, debounce counter, rise-detect event), instantiated once per sensor.
- The queue and output FSM stay in the top level.

Test Plan:
- Clean press on coin_rs1_n with DEBOUNCE_CYCLES=16: coin=1 for exactly one cycle, 21 edges after first low sample; coin_reject stays 0; queue_count returns to 0.
- Bounce on coin_rs2_n of 5-cycle low glitches, then a stable low: no event from the glitches; a single coin=2 pulse after the stable press.
- accept_en=0, three coins inserted (RS1, RS2, RS1), QUEUE_DEPTH=2:
  - queue_count reaches 2 and the third coin pulses coin_reject.
  - After accept_en=1: coin=1, then coin=2, each pulse followed by 2 zero cycles (GAP_CYCLES+1).
- Both sensors pressed simultaneously (same debounced edge): coin_reject pulses once; no coin pulse; queue_count stays 0.
- Full queue with push and pop in the same cycle: queue_count unchanged, no reject, FIFO order preserved.
- Reset asserted mid-EMIT with 2 coins queued: coin=0 and queue_count=0 immediately (asynchronous). A sensor held low through reset release yields exactly one coin pulse.
